rc4_prga_decrypt: RTL and testbench

Parametrised RC4 keystream generator (PRGA) and decryptor for the S-memory / encrypted-ROM / decrypted-RAM datapath, following the KSA stage. It takes an initialised 256-byte S array in S-memory and decrypts MSG_LEN bytes from the encrypted ROM into the decrypted RAM. It adds a runtime plaintext-validity check for key search: when enabled, it aborts on the first non-printable byte and flags failure.

---
 rtl/rc4_prga_decrypt.sv | 204 ++++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : rc4_prga_decrypt
// Description : RC4 keystream generator (PRGA) and decryptor. Walks an
//               initialised S array, XORs the keystream with the encrypted
//               ROM and writes plaintext to the decrypted RAM, optionally
//               aborting on the first non-printable byte (key search aid).
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_prga_decrypt #(
  parameter int         MSG_LEN = 32,
  parameter int         ADDR_W  = 5,
  parameter logic [7:0] CHAR_LO = 8'd97,
  parameter logic [7:0] CHAR_HI = 8'd122
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              check_en,
  input  logic [7:0]        s_memory_q,
  input  logic [7:0]        e_rom_q,
  output logic [7:0]        s_memory_addr,
  output logic [7:0]        s_memory_data,
  output logic              s_wren,
  output logic [ADDR_W-1:0] e_rom_addr,
  output logic [ADDR_W-1:0] d_ram_addr,
  output logic [7:0]        d_ram_data,
  output logic              d_ram_wren,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W:0]   bytes_done,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RD_I = 4'd1,
    WT_I = 4'd2,
    RD_J = 4'd3,
    WT_J = 4'd4,
    WR_I = 4'd5,
    WR_J = 4'd6,
    RD_F = 4'd7,
    WT_F = 4'd8,
    WR_D = 4'd9,
    DONE = 4'd10
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(MSG_LEN - 1);

  state_t              state_q, state_d;
  logic [7:0]          i_q, i_d, j_q, j_d;
  logic [7:0]          si_q, si_d, sj_q, sj_d;
  logic [7:0]          f_q, f_d, e_q, e_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W:0]     bytes_done_q, bytes_done_d;
  logic                fail_q, fail_d;
  logic                chk_en_q, chk_en_d;

  logic [7:0]          w_plain;
  logic                w_byte_ok;

  // Plaintext byte and its printable-character test (lowercase range or space)
  assign w_plain   = f_q ^ e_q;
  assign w_byte_ok = ((w_plain >= CHAR_LO) && (w_plain <= CHAR_HI)) || (w_plain == 8'd32);

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      i_q          <= 8'd0;
      j_q          <= 8'd0;
      si_q         <= 8'd0;
      sj_q         <= 8'd0;
      f_q          <= 8'd0;
      e_q          <= 8'd0;
      k_q          <= '0;
      bytes_done_q <= '0;
      fail_q       <= 1'b0;
      chk_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      si_q         <= si_d;
      sj_q         <= sj_d;
      f_q          <= f_d;
      e_q          <= e_d;
      k_q          <= k_d;
      bytes_done_q <= bytes_done_d;
      fail_q       <= fail_d;
      chk_en_q     <= chk_en_d;
    end
  end

  // Next-state logic: nine-state per-byte walk, read data captured in wait states
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    si_d         = si_q;
    sj_d         = sj_q;
    f_d          = f_q;
    e_d          = e_q;
    k_d          = k_q;
    bytes_done_d = bytes_done_q;
    fail_d       = fail_q;
    chk_en_d     = chk_en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d          = 8'd1;
          j_d          = 8'd0;
          k_d          = '0;
          bytes_done_d = '0;
          fail_d       = 1'b0;
          chk_en_d     = check_en;
          state_d      = RD_I;
        end
      end
      RD_I: state_d = WT_I;
      WT_I: begin
        si_d    = s_memory_q;
        j_d     = j_q + s_memory_q;
        state_d = RD_J;
      end
      RD_J: state_d = WT_J;
      WT_J: begin
        sj_d    = s_memory_q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: state_d = RD_F;
      RD_F: state_d = WT_F;
      WT_F: begin
        f_d     = s_memory_q;
        e_d     = e_rom_q;
        state_d = WR_D;
      end
      WR_D: begin
        bytes_done_d = {1'b0, k_q} + {{ADDR_W{1'b0}}, 1'b1};
        if (chk_en_q && !w_byte_ok) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else if (k_q == c_last_k) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          i_d     = i_q + 8'd1;
          state_d = RD_I;
        end
      end
      DONE: begin
        if (!start) begin
          fail_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from the state and data registers only
  always_comb begin
    s_memory_addr = 8'd0;
    s_memory_data = 8'd0;
    s_wren        = 1'b0;
    e_rom_addr    = '0;
    d_ram_addr    = '0;
    d_ram_data    = 8'd0;
    d_ram_wren    = 1'b0;
    case (state_q)
      RD_I: s_memory_addr = i_q;
      RD_J: s_memory_addr = j_q;
      WR_I: begin
        s_memory_addr = i_q;
        s_memory_data = sj_q;
        s_wren        = 1'b1;
      end
      WR_J: begin
        s_memory_addr = j_q;
        s_memory_data = si_q;
        s_wren        = 1'b1;
      end
      RD_F: begin
        s_memory_addr = si_q + sj_q;
        e_rom_addr    = k_q;
      end
      WR_D: begin
        d_ram_addr = k_q;
        d_ram_data = w_plain;
        d_ram_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign done       = (state_q == DONE);
  assign fail       = fail_q;
  assign bytes_done = bytes_done_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_prga_decrypt
// Description : Directed self-checking bench for rc4_prga_decrypt with
//               behavioural S-memory, encrypted ROM and decrypted RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 4;
  localparam int ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              check_en = 1'b0;
  logic [7:0]        s_memory_q = 8'd0;
  logic [7:0]        e_rom_q = 8'd0;
  logic [7:0]        s_memory_addr;
  logic [7:0]        s_memory_data;
  logic              s_wren;
  logic [ADDR_W-1:0] e_rom_addr;
  logic [ADDR_W-1:0] d_ram_addr;
  logic [7:0]        d_ram_data;
  logic              d_ram_wren;
  logic              done;
  logic              fail;
  logic [ADDR_W:0]   bytes_done;
  logic [3:0]        state;

  rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .check_en(check_en),
    .s_memory_q(s_memory_q), .e_rom_q(e_rom_q),
    .s_memory_addr(s_memory_addr), .s_memory_data(s_memory_data), .s_wren(s_wren),
    .e_rom_addr(e_rom_addr), .d_ram_addr(d_ram_addr), .d_ram_data(d_ram_data),
    .d_ram_wren(d_ram_wren), .done(done), .fail(fail),
    .bytes_done(bytes_done), .state(state)
  );

  always #5 clk = ~clk;

  logic [7:0] smem [256];
  logic [7:0] rom  [MSG_LEN];
  logic [7:0] dram [MSG_LEN];

  int checks = 0;
  int errors = 0;

  // Monitor state
  int          cyc = 0;
  int          s_wr_n = 0;
  logic [7:0]  wr_addr [2];
  logic [7:0]  wr_data [2];
  int          wr_cyc  [2];
  int          rom_max = 0;
  int          act = 0;

  // Synchronous memories with one-cycle read latency
  always @(posedge clk) begin
    if (s_wren) smem[s_memory_addr] <= s_memory_data;
    s_memory_q <= smem[s_memory_addr];
    e_rom_q    <= rom[e_rom_addr];
    if (d_ram_wren) dram[d_ram_addr] <= d_ram_data;
  end

  // Activity logging
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (s_wren) begin
      if (s_wr_n < 2) begin
        wr_addr[s_wr_n] = s_memory_addr;
        wr_data[s_wr_n] = s_memory_data;
        wr_cyc[s_wr_n]  = cyc;
      end
      s_wr_n = s_wr_n + 1;
    end
    if (int'(e_rom_addr) > rom_max) rom_max = int'(e_rom_addr);
    if (s_wren || d_ram_wren || s_memory_addr != 8'd0 || e_rom_addr != '0 || d_ram_addr != '0)
      act = act + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] r0, input logic [7:0] r1,
                      input logic [7:0] r2, input logic [7:0] r3);
    @(negedge clk);
    for (int n = 0; n < 256; n++) smem[n] = 8'(n);
    rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
    for (int n = 0; n < MSG_LEN; n++) dram[n] = 8'hEE;
    s_wr_n  = 0;
    rom_max = 0;
  endtask

  // Raise start, return edges from the accepting edge until done is seen
  task automatic run(input logic ce, output int edges);
    @(negedge clk);
    check_en = ce;
    start    = 1'b1;
    @(posedge clk); #1;
    check("accept_state", 32'(state), 1);
    edges = 0;
    while (!done && edges < 500) begin
      @(posedge clk); #1;
      edges++;
    end
    check("done_timeout", 32'(done), 1);
  endtask

  task automatic finish_run();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("back_idle", 32'(state), 0);
    check("idle_done", 32'(done), 0);
    check("idle_fail", 32'(fail), 0);
  endtask

  logic [7:0] exp1 [MSG_LEN] = '{8'h02, 8'h05, 8'h07, 8'h0D};
  logic [7:0] exp2 [MSG_LEN] = '{8'h61, 8'h62, 8'h63, 8'h20};

  initial begin
    int edges;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_outs", 32'({s_wren, d_ram_wren, done, fail}), 0);
    check("rst_addr", 32'({s_memory_addr, s_memory_data, d_ram_data}), 0);
    check("rst_bytes", 32'(bytes_done), 0);
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: identity S, zero ciphertext, no check
    load(8'h00, 8'h00, 8'h00, 8'h00);
    run(1'b0, edges);
    check("s1_edges", 32'(edges), 36);
    check("s1_fail", 32'(fail), 0);
    check("s1_bytes", 32'(bytes_done), 4);
    check("s1_state", 32'(state), 10);
    for (int m = 0; m < MSG_LEN; m++) check($sformatf("s1_d%0d", m), 32'(dram[m]), 32'(exp1[m]));
    check("s1_S1", 32'(smem[1]), 1);
    check("s1_S2", 32'(smem[2]), 3);
    check("s1_S3", 32'(smem[3]), 5);
    check("s1_S4", 32'(smem[4]), 9);
    check("s1_S5", 32'(smem[5]), 2);
    check("s1_S9", 32'(smem[9]), 4);
    // Scenario 4: self-swap on byte 0 writes address 1 twice back to back
    check("s4_addr0", 32'(wr_addr[0]), 1);
    check("s4_addr1", 32'(wr_addr[1]), 1);
    check("s4_data0", 32'(wr_data[0]), 1);
    check("s4_data1", 32'(wr_data[1]), 1);
    check("s4_consec", 32'(wr_cyc[1] - wr_cyc[0]), 1);
    finish_run();
    check("s1_bytes_hold", 32'(bytes_done), 4);

    // Scenario 2: printable plaintext "abc "
    load(8'h63, 8'h67, 8'h64, 8'h2D);
    run(1'b1, edges);
    check("s2_edges", 32'(edges), 36);
    check("s2_fail", 32'(fail), 0);
    check("s2_bytes", 32'(bytes_done), 4);
    for (int m = 0; m < MSG_LEN; m++) check($sformatf("s2_d%0d", m), 32'(dram[m]), 32'(exp2[m]));
    finish_run();

    // Scenario 3: byte 1 decrypts to 0x05 and aborts the run
    load(8'h63, 8'h00, 8'h64, 8'h2D);
    run(1'b1, edges);
    check("s3_edges", 32'(edges), 18);
    check("s3_fail", 32'(fail), 1);
    check("s3_bytes", 32'(bytes_done), 2);
    check("s3_d0", 32'(dram[0]), 'h61);
    check("s3_d1", 32'(dram[1]), 'h05);
    check("s3_d2", 32'(dram[2]), 'hEE);
    check("s3_rom_max", 32'(rom_max), 1);

    // Scenario 6: hold start in DONE, then release
    act = 0;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("s6_done_held", 32'(n), 10);
    check("s6_no_activity", 32'(act), 0);
    check("s6_fail_held", 32'(fail), 1);
    finish_run();
    check("s6_bytes_hold", 32'(bytes_done), 2);

    // Scenario 5: reset during WR_I of byte 2, then a clean re-run
    load(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check_en = 1'b0;
    start    = 1'b1;
    n = 0;
    edges = 0;
    while (n < 3 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (state == 4'd5) n++;
    end
    check("s5_reach_wri", 32'(n), 3);
    check("s5_wren_before", 32'(s_wren), 1);
    #2;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("s5_wren_drop", 32'(s_wren), 0);
    check("s5_state_idle", 32'(state), 0);
    @(negedge clk);
    rst = 1'b1;
    load(8'h00, 8'h00, 8'h00, 8'h00);
    run(1'b0, edges);
    check("s5_edges", 32'(edges), 36);
    check("s5_fail", 32'(fail), 0);
    for (int m = 0; m < MSG_LEN; m++) check($sformatf("s5_d%0d", m), 32'(dram[m]), 32'(exp1[m]));
    check("s5_S9", 32'(smem[9]), 4);
    finish_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
